skid_buffer: RTL
================

// Module: skid_buffer
//
// PURPOSE
// - Two-entry valid/ready register slice that registers the backward (ready) path.
// - din_rdy is a flop output with no combinational path from dout_rdy, so it breaks long ready chains.
// - Companion to the single-entry forward pipeline buffer. Placed at stage boundaries where the
//   pass-thru ready path would set the critical path.
// - Full throughput: 1 beat/cycle sustained. Latency: 1 cycle.
//
// PARAMETERS
// - WIDTH   32   payload width in bits
//
// PORTS
// - clk        in   1      clock; all logic on posedge
// - rst        in   1      reset, synchronous, active-high
// - din        in   WIDTH  upstream payload
// - din_vld    in   1      upstream valid
// - din_rdy    out  1      upstream ready; registered, never depends combinationally on any input
// - dout       out  WIDTH  downstream payload; registered (main entry)
// - dout_vld   out  1      downstream valid; registered
// - dout_rdy   in   1      downstream ready
// - flush      in   1      synchronous discard of contents (only with SKID_BUFFER_FLUSH_EN)
//
// BEHAVIOUR
// - Handshakes: in_xfer = din_vld & din_rdy; out_xfer = dout_vld & dout_rdy.
// - Storage: main register (drives dout) and skid register.
// - State: EMPTY (0 entries), BUSY (main valid), FULL (main + skid valid).
// - Reset (rst high at posedge): state=EMPTY, dout_vld=0, dout='0, skid='0, din_rdy=0.
//   din_rdy rises at the first posedge with rst low. Reset mid-transfer drops all held data.
// - Transitions:
//     EMPTY : in_xfer              -> BUSY,  main<=din
//     BUSY  : in_xfer &  out_xfer  -> BUSY,  main<=din
//             in_xfer & ~out_xfer  -> FULL,  skid<=din
//            ~in_xfer &  out_xfer  -> EMPTY
//             otherwise            -> BUSY,  hold
//     FULL  : out_xfer             -> BUSY,  main<=skid  (in_xfer impossible: din_rdy=0)
//             otherwise            -> FULL,  hold
// - dout_vld = (state != EMPTY), registered.
// - din_rdy <= (next_state != FULL), registered.
// - Ordering: strict FIFO. The skid entry always drains after main; no beat is lost or duplicated.
// - Stability: while dout_vld & ~dout_rdy, dout and dout_vld hold.
//   din_vld may be asserted while din_rdy=0; it is ignored until din_rdy=1.
// - Boundaries:
//     FULL with dout_rdy=1 -> din_rdy returns to 1 on the next cycle (one bubble on input only).
//     Output sustains 1/cycle.
//     EMPTY with dout_rdy=1 -> no output until data arrives. No combinational flow-through.
// - Payload is held only; no arithmetic on din/dout.
//
// CONFIGURATION
// - SKID_BUFFER_FLUSH_EN defined:
//     - flush port exists.
//     - flush=1 at posedge (rst=0): state=EMPTY, dout_vld=0, din_rdy<=1.
//       Any in_xfer/out_xfer that cycle is discarded.
//     - rst has priority over flush. dout/skid data are not cleared.
// - SKID_BUFFER_FLUSH_EN undefined:
//     - flush port is absent.
//     - Behaviour is identical to the defined case with flush tied to 0.
//
// TESTING
// - Reset: rst=1 for 3 cycles, then 0.
//     -> during reset dout_vld=0, din_rdy=0, dout=0; din_rdy=1 one cycle after release.
// - Streaming: din=1,2,3..16 back-to-back, dout_rdy=1 throughout.
//     -> dout=1..16 on consecutive cycles, 1-cycle latency, din_rdy stays 1.
// - Stall: send A,B; dout_rdy=0 for 4 cycles.
//     -> FULL, din_rdy=0, dout=A held.
//     -> Then dout_rdy=1: A then B out, no loss or duplication.
// - Random: random din_vld/dout_rdy (50%), 1000 beats.
//     -> output order equals input order.
//     -> din_rdy never changes in the same cycle as dout_rdy toggles.
// - Flush (macro on): flush while FULL with A,B held.
//     -> next cycle dout_vld=0, din_rdy=1; the following beat C emerges first.
// - Reset mid-op: rst while FULL.
//     -> EMPTY; pre-reset data never appears on dout.

Source files
------------

// File: rtl/skid_buffer_if.sv
// Valid/ready handshake bundle for the skid buffer.
// The upstream side (din*) and the downstream side (dout*) share one bundle:
//   slave  - the buffer's view: accepts din, produces dout
//   master - the environment's view: produces din, accepts dout
interface skid_buffer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic             din_rdy;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             dout_rdy;

    modport slave (
        input  din,
        input  din_vld,
        output din_rdy,
        output dout,
        output dout_vld,
        input  dout_rdy
    );

    modport master (
        output din,
        output din_vld,
        input  din_rdy,
        input  dout,
        input  dout_vld,
        output dout_rdy
    );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice with a registered ready path.
// din_rdy, dout and dout_vld all come straight from flops, so nothing on the
// downstream side reaches the upstream side within a cycle.
// Optional feature macro: SKID_BUFFER_FLUSH_EN adds a synchronous flush port.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held; dout_vld=0, din_rdy=1
//   ST_BUSY  | main entry valid; skid free; din_rdy=1
//   ST_FULL  | main and skid valid; din_rdy=0 until main drains
module skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SKID_BUFFER_FLUSH_EN
    input  logic         flush,
`endif
    skid_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             vld_q,   vld_d;
    logic             rdy_q,   rdy_d;
    logic             in_xfer;
    logic             out_xfer;
    logic             flush_w;

`ifdef SKID_BUFFER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Handshakes use the registered ready/valid, never a live input on the other side.
    assign in_xfer  = bus.din_vld & rdy_q;
    assign out_xfer = vld_q & bus.dout_rdy;

    // Next-state and data steering; flush overrides the transfer decision but keeps payload flops.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_BUSY;
                    main_d  = bus.din;
                end
            end
            ST_BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = bus.din;
                end else if (in_xfer) begin
                    state_d = ST_FULL;
                    skid_d  = bus.din;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // din_rdy is low here, so only the drain of main can happen.
                if (out_xfer) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (flush_w) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        vld_d = (state_d != ST_EMPTY);
        rdy_d = (state_d != ST_FULL);
    end

    // State, payload and handshake flops; reset drops everything and holds din_rdy low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.dout     = main_q;
    assign bus.dout_vld = vld_q;
    assign bus.din_rdy  = rdy_q;

endmodule
